// File: rtl/json_frame_builder_if.sv
// Bundles the request handshake, the frame bus toward json_to_uart and the
// returning done level into one connection.
interface json_frame_builder_if;
    logic              req;
    logic [7:0]        key;
    logic [15:0]       value;
    logic              busy;
    logic              err;
    logic [0:31][7:0]  json_str;
    logic [7:0]        json_len;
    logic              start;
    logic              done;

    modport master (
        output req, key, value, done,
        input  busy, err, json_str, json_len, start
    );

    modport slave (
        input  req, key, value, done,
        output busy, err, json_str, json_len, start
    );
endinterface

// File: rtl/json_frame_builder.sv
// Converts a 16-bit value to decimal with a serial double-dabble, wraps it as
// {"K":<digits>} for json_to_uart, then waits for that block's done edge.
module json_frame_builder #(
    parameter int unsigned DONE_TIMEOUT = 2_000_000
) (
    input  logic               clk,
    input  logic               rst,
    json_frame_builder_if.slave bus
);
    localparam int unsigned   TW       = $clog2(DONE_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CONVERT, BUILD, START, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        key_q, key_d;
    logic [15:0]       shreg_q, shreg_d;
    logic [19:0]       bcd_q, bcd_d;
    logic [3:0]        iter_q, iter_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [0:31][7:0]  str_q, str_d;
    logic [7:0]        len_q, len_d;
    logic              done_q;
    logic              busy_q;
    logic              start_q;
    logic              err_c;
    logic              rise_c;
    logic [19:0]       adj_c;
    logic [19:0]       aligned_c;
    logic [2:0]        nd_c;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        shreg_d   = shreg_q;
        bcd_d     = bcd_q;
        iter_d    = iter_q;
        tmo_d     = tmo_q;
        str_d     = str_q;
        len_d     = len_q;
        err_c     = 1'b0;
        adj_c     = '0;
        aligned_c = '0;
        nd_c      = 3'd1;
        rise_c    = bus.done & ~done_q;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    key_d   = bus.key;
                    shreg_d = bus.value;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                for (int i = 0; i < 5; i++) begin
                    adj_c[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                                : bcd_q[4*i +: 4];
                end
                {bcd_d, shreg_d} = {adj_c, shreg_q} << 1;
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd15) state_d = BUILD;
            end
            BUILD: begin
                for (int i = 1; i < 5; i++) begin
                    if (bcd_q[4*i +: 4] != 4'd0) nd_c = 3'(i + 1);
                end
                // Left-justify so the leading significant digit always sits in bits 19:16.
                aligned_c = bcd_q << {3'd5 - nd_c, 2'b00};
                str_d    = '0;
                str_d[0] = 8'h7B;
                str_d[1] = 8'h22;
                str_d[2] = key_q;
                str_d[3] = 8'h22;
                str_d[4] = 8'h3A;
                for (int p = 0; p < 5; p++) begin
                    if (3'(p) < nd_c)       str_d[5+p] = {4'h3, aligned_c[19-4*p -: 4]};
                    else if (3'(p) == nd_c) str_d[5+p] = 8'h7D;
                end
                if (nd_c == 3'd5) str_d[10] = 8'h7D;
                len_d   = {5'd0, nd_c} + 8'd6;
                state_d = START;
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (rise_c) begin
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // done_q tracks every cycle so edges outside WAIT_DONE are silently consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            shreg_q <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            tmo_q   <= '0;
            str_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            tmo_q   <= tmo_d;
            str_q   <= str_d;
            len_q   <= len_d;
            done_q  <= bus.done;
            busy_q  <= (state_d != IDLE);
            start_q <= (state_d == START);
        end
    end

    assign bus.busy     = busy_q;
    assign bus.start    = start_q;
    assign bus.err      = err_c;
    assign bus.json_str = str_q;
    assign bus.json_len = len_q;
endmodule

// File: tb/tb_json_frame_builder.sv
// Randomized bench for json_frame_builder: a transaction-timeline model checks
// every cycle, and literal frames pin the model on the documented cases.
module tb_json_frame_builder;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst;
    json_frame_builder_if bus();

    json_frame_builder #(.DONE_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;
    int tbCyc = 0;

    bit               mActive = 1'b0;
    int               mCyc = 0;
    logic [7:0]       mKey = '0;
    logic [15:0]      mVal = '0;
    logic             mDonePrev = 1'b0;
    logic [0:31][7:0] expStr = '0;
    logic [7:0]       expLen = '0;

    function automatic void buildFrame(input logic [7:0] k, input logic [15:0] v,
                                       output logic [0:31][7:0] f, output logic [7:0] n);
        string s;
        s = $sformatf("%0d", v);
        f = '0;
        f[0] = 8'h7B;
        f[1] = 8'h22;
        f[2] = k;
        f[3] = 8'h22;
        f[4] = 8'h3A;
        for (int i = 0; i < s.len(); i++) f[5+i] = s[i];
        f[5+s.len()] = 8'h7D;
        n = 8'(6 + s.len());
    endfunction

    // Model timeline: cycle 1 follows the accept edge, frame lands after 17,
    // start shows in 18, waiting begins at 19 and times out in cycle 18+TMO.
    always @(posedge clk) begin
        bit rise;
        rise = bus.done && !mDonePrev;
        if (rst) begin
            mActive   = 1'b0;
            mCyc      = 0;
            expStr    = '0;
            expLen    = '0;
            mDonePrev = 1'b0;
        end else begin
            mDonePrev = bus.done;
            if (!mActive) begin
                if (bus.req) begin
                    mActive = 1'b1;
                    mCyc    = 1;
                    mKey    = bus.key;
                    mVal    = bus.value;
                end
            end else begin
                if (mCyc == 17) buildFrame(mKey, mVal, expStr, expLen);
                if (mCyc >= 19 && (rise || mCyc == 18 + TMO)) mActive = 1'b0;
                else mCyc++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            logic expErr;
            expErr = mActive && (mCyc == 18 + TMO) && !(bus.done && !mDonePrev);
            checkOutput("busy",     256'(bus.busy),     256'(mActive));
            checkOutput("start",    256'(bus.start),    256'(mActive && mCyc == 18));
            checkOutput("err",      256'(bus.err),      256'(expErr));
            checkOutput("json_len", 256'(bus.json_len), 256'(expLen));
            checkOutput("json_str", bus.json_str,       expStr);
        end
    end

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            tbCyc++;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] k, input logic [15:0] v);
        bus.req   = 1'b1;
        bus.key   = k;
        bus.value = v;
        advance(1);
        bus.req = 1'b0;
        tbCyc   = 1;
    endtask

    task automatic waitIdle(input int maxCycles);
        bit reached;
        reached = 1'b0;
        for (int i = 0; i < maxCycles && !reached; i++) begin
            if (!mActive) reached = 1'b1;
            else advance(1);
        end
        if (!reached) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_wait: still active after %0d cycles, expected idle", maxCycles);
        end
    endtask

    task automatic checkFrameAtStart(input string name, input logic [255:0] frame, input logic [7:0] len);
        advance(17);
        @(negedge clk);
        checkOutput({name, "_start"}, 256'(bus.start), 256'(1));
        checkOutput({name, "_len"},   256'(bus.json_len), 256'(len));
        checkOutput({name, "_str"},   bus.json_str, frame);
    endtask

    initial begin
        logic [7:0]  k;
        logic [15:0] v;
        int sel;

        rst = 1'b1;
        bus.req = 1'b0;
        bus.key = '0;
        bus.value = '0;
        bus.done = 1'b0;
        advance(2);
        rst = 1'b0;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("reset_busy",  256'(bus.busy),     256'(0));
        checkOutput("reset_start", 256'(bus.start),    256'(0));
        checkOutput("reset_err",   256'(bus.err),      256'(0));
        checkOutput("reset_len",   256'(bus.json_len), 256'(0));
        checkOutput("reset_str",   bus.json_str,       256'(0));
        advance(1);

        applyStimulus(8'h54, 16'd11);
        checkFrameAtStart("t11", {64'h7B2254223A31317D, 192'h0}, 8'd8);
        advance(1);
        @(negedge clk);
        checkOutput("t11_start_drop", 256'(bus.start), 256'(0));
        advance(2);
        bus.done = 1'b1;
        waitIdle(300);

        bus.done = 1'b0;
        applyStimulus(8'h4B, 16'd0);
        checkFrameAtStart("zero", {56'h7B224B223A307D, 200'h0}, 8'd7);
        advance(3);
        bus.done = 1'b1;
        waitIdle(300);

        // done left high from the previous frame must not end this one early.
        applyStimulus(8'h56, 16'd65535);
        checkFrameAtStart("max", {88'h7B2256223A36353533357D, 168'h0}, 8'd11);
        bus.done = 1'b0;
        advance(2);
        bus.done = 1'b1;
        waitIdle(300);

        applyStimulus(8'h56, 16'd10000);
        checkFrameAtStart("tenk", {88'h7B2256223A31303030307D, 168'h0}, 8'd11);
        bus.done = 1'b0;
        advance(2);
        bus.done = 1'b1;
        waitIdle(300);

        bus.done = 1'b0;
        applyStimulus(8'h52, 16'd1234);
        advance(4);
        bus.req = 1'b1;
        bus.value = 16'd99;
        advance(1);
        bus.req = 1'b0;
        advance(12);
        @(negedge clk);
        checkOutput("ignored_req_str", bus.json_str, {80'h7B2252223A313233347D, 176'h0});
        checkOutput("ignored_req_len", 256'(bus.json_len), 256'(10));
        advance(2);
        bus.req = 1'b1;
        advance(1);
        bus.req = 1'b0;
        bus.done = 1'b1;
        waitIdle(300);
        applyStimulus(8'h52, 16'd99);
        checkFrameAtStart("next99", {64'h7B2252223A39397D, 192'h0}, 8'd8);
        advance(1);
        bus.done = 1'b0;
        advance(2);
        bus.done = 1'b1;
        waitIdle(300);

        for (int rep = 0; rep < 2; rep++) begin
            bus.done = (rep == 1);
            advance(3);
            applyStimulus(8'h5A, 16'(42 + rep));
            advance(17);
            advance(TMO);
            @(negedge clk);
            checkOutput("timeout_err",  256'(bus.err),  256'(1));
            checkOutput("timeout_busy", 256'(bus.busy), 256'(1));
            advance(1);
            @(negedge clk);
            checkOutput("timeout_err_drop", 256'(bus.err),  256'(0));
            checkOutput("timeout_idle",     256'(bus.busy), 256'(0));
        end

        bus.done = 1'b0;
        advance(2);
        applyStimulus(8'h6B, 16'd500);
        advance(7);
        rst = 1'b1;
        advance(1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_busy",  256'(bus.busy),     256'(0));
        checkOutput("midreset_start", 256'(bus.start),    256'(0));
        checkOutput("midreset_err",   256'(bus.err),      256'(0));
        checkOutput("midreset_len",   256'(bus.json_len), 256'(0));
        checkOutput("midreset_str",   bus.json_str,       256'(0));
        for (int i = 0; i < 30; i++) begin
            advance(1);
            @(negedge clk);
            checkOutput("midreset_no_start", 256'(bus.start), 256'(0));
        end
        advance(1);
        applyStimulus(8'h6B, 16'd7);
        checkFrameAtStart("after_reset", {56'h7B226B223A377D, 200'h0}, 8'd7);
        advance(2);
        bus.done = 1'b1;
        waitIdle(300);

        for (int n = 0; n < 25; n++) begin
            k   = 8'($urandom_range(33, 126));
            sel = $urandom_range(0, 4);
            case (sel)
                0:       v = 16'd0;
                1:       v = 16'd65535;
                2:       v = 16'($urandom_range(0, 9));
                3:       v = 16'($urandom_range(10, 999));
                default: v = 16'($urandom);
            endcase
            applyStimulus(k, v);
            advance($urandom_range(0, 30));
            bus.done = 1'b0;
            advance($urandom_range(1, 25));
            bus.done = 1'b1;
            waitIdle(300);
        end

        advance(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/json_frame_builder.md
# json_frame_builder

Upstream stage of the JSON-over-UART path. It accepts a one-character key and a 16-bit unsigned sensor value, converts the value to ASCII decimal with a sequential double-dabble converter, and assembles a frame of the form {"K":<digits>} into the 32-byte array. It then pulses `start` to the `json_to_uart` block and waits for that block's `done` before accepting the next request.

## Interface
Parameters:
- DONE_TIMEOUT, default 2_000_000: maximum cycles to wait in WAIT_DONE for a `done` rising edge. At 50 MHz this is 40 ms.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe. Sampled only in IDLE.
- key  in  8  ASCII key character, latched on accept.
- value  in  16  unsigned value, latched on accept.
- busy  out  1  high from the cycle after accept until the return to IDLE.
- err  out  1  one-cycle pulse when the DONE_TIMEOUT wait expires.
- json_str  out  8 x [0:31]  frame bytes, wired to `json_to_uart.json_str`.
- json_len  out  8  frame length, wired to `json_to_uart.json_len`.
- start  out  1  one-cycle pulse to `json_to_uart.start`.
- done  in  1  from `json_to_uart.done`. Only its rising edge is used.

## Operation
- States: IDLE, CONVERT, BUILD, START, WAIT_DONE.
- IDLE:
  - When `req`=1, latch `key` and `value`, clear the BCD register (20 bits, 5 digits) and the 4-bit iteration counter, then go to CONVERT.
- CONVERT, 16 cycles:
  - Each cycle, add 3 to every BCD digit that is >= 5, then shift {bcd, value_shreg} left by 1.
  - Leave CONVERT after iteration 15 (counter wraps 15 -> done) and go to BUILD.
- BUILD, 1 cycle:
  - Find the most significant nonzero digit. If all digits are zero, emit the single digit '0'.
  - Write the frame as bytes 0x7B '{', 0x22 '"', key, 0x22, 0x3A ':', the digits (0x30 + d, most significant first), then 0x7D '}'.
  - json_len = 6 + ndigits. ndigits is in 1..5, so json_len is in 7..11.
  - Write 0x00 to every byte at index >= json_len.
  - Go to START.
- START, 1 cycle: `start`=1, clear the timeout counter, go to WAIT_DONE.
- WAIT_DONE:
  - Register `done` as done_q. A rising edge is `done` & ~done_q.
  - On a rising edge, go to IDLE.
  - Otherwise, if the timeout counter reaches DONE_TIMEOUT-1, pulse `err` for one cycle and go to IDLE.
  - Otherwise, increment the timeout counter.
  - Edge detection makes a `done` level left high by the previous frame harmless.
- `json_str` and `json_len` hold from BUILD until the next BUILD. They stay stable throughout the UART transmission.
- `req` is ignored outside IDLE and is never queued.
- done_q updates in every state, so an edge that happens outside WAIT_DONE is consumed and has no effect.

## Timing
- Reset, effective at the next clk edge, sets:
  - state = IDLE;
  - busy, err, start = 0;
  - json_len = 0 and every `json_str` byte = 0x00;
  - BCD, counters and done_q = 0.
- Reset mid-operation aborts any state. `start` is not asserted afterwards.
- Cycle numbering: the accept edge is cycle 0.
  - CONVERT occupies cycles 1-16.
  - BUILD is cycle 17. `json_str` and `json_len` are valid from cycle 18.
  - `start` is high in cycle 18 only, so `json_str` is valid in the same cycle `start` is seen.
  - Earliest return to IDLE: 1 cycle after the `done` edge is sampled.
- Back-to-back frames: a new `req` is accepted in the first IDLE cycle.
- `busy` is 0 in IDLE and 1 in every other state. It is registered, so it rises at cycle 1.

## Test plan
- key 'T' (0x54), value 11:
  - At cycle 18, `json_str[0:7]` = 7B 22 54 22 3A 31 31 7D and `json_len` = 8.
  - `start` is high for exactly one cycle (cycle 18).
  - With `json_to_uart` attached, `uart_out` serialises those 8 bytes.
- value 0:
  - Bytes = 7B 22 4B 22 3A 30 7D (key 'K') and `json_len` = 7.
  - Bytes 7..31 = 0x00.
- value 65535:
  - Digit bytes = 36 35 35 33 35 and `json_len` = 11.
  - byte 10 = 7D. value 10000 gives digits 31 30 30 30 30.
- `req` pulsed again at cycles 5 and 20 with value 99:
  - Both pulses are ignored and the frame still carries the first value.
  - After the `done` edge, a new `req` produces the new frame, with `start` 18 cycles after its accept.
- `done` held at 0, DONE_TIMEOUT=100:
  - `err` pulses once, 100 cycles after the START cycle. The block is then in IDLE and `busy`=0.
  - Repeat with `done` held at 1: same result, since there is no edge.
- `rst` asserted at cycle 8 (mid-CONVERT):
  - `start` never rises.
  - From the next edge, every output is zero and every `json_str` byte is 0x00.
  - A subsequent `req` with value 7 produces 7B 22 k 22 3A 37 7D.
